// File: rtl/register_bank.sv
// register_bank: per-context architectural register file with HI/LO pair.
// Stores 2**ADDR_W GPRs and one HI/LO pair for each of 2**CTX_W contexts.
// Two combinational read ports see a same-cycle write through a bypass path.
// Register 0 of every context is hard-wired to zero.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   ctx_sel               context used by all reads and writes this cycle
//   rs_addr, rt_addr      read port indices
//   rd_addr, rd_data      write index and data, enabled by reg_write
//   hilo_write            writes hi_in/lo_in to the active context's HI/LO
//   rs_data, rt_data      read port data (combinational)
//   hi_out, lo_out        HI/LO of the active context (combinational)
module register_bank #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CTX_W  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CTX_W-1:0]  ctx_sel,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              reg_write,
  input  logic              hilo_write,
  input  logic [DATA_W-1:0] hi_in,
  input  logic [DATA_W-1:0] lo_in,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  localparam int unsigned NUM_CTX  = 1 << CTX_W;
  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  logic [DATA_W-1:0] gpr [NUM_CTX][NUM_REGS];
  logic [DATA_W-1:0] hi  [NUM_CTX];
  logic [DATA_W-1:0] lo  [NUM_CTX];

  logic gpr_we;
  assign gpr_we = reg_write && (rd_addr != '0);

  // Storage update; reset clears every context and wins over both writes.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned c = 0; c < NUM_CTX; c++) begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
          gpr[c][r] <= '0;
        end
        hi[c] <= '0;
        lo[c] <= '0;
      end
    end else begin
      if (gpr_we) begin
        gpr[ctx_sel][rd_addr] <= rd_data;
      end
      if (hilo_write) begin
        hi[ctx_sel] <= hi_in;
        lo[ctx_sel] <= lo_in;
      end
    end
  end

  // Read port A: zero register, then bypass, then storage.
  always_comb begin
    rs_data = '0;
    if (!reset && (rs_addr != '0)) begin
      if (reg_write && (rd_addr == rs_addr)) begin
        rs_data = rd_data;
      end else begin
        rs_data = gpr[ctx_sel][rs_addr];
      end
    end
  end

  // Read port B: same rules as port A.
  always_comb begin
    rt_data = '0;
    if (!reset && (rt_addr != '0)) begin
      if (reg_write && (rd_addr == rt_addr)) begin
        rt_data = rd_data;
      end else begin
        rt_data = gpr[ctx_sel][rt_addr];
      end
    end
  end

  // HI/LO read with write-through; forced to zero while reset is held.
  always_comb begin
    hi_out = '0;
    lo_out = '0;
    if (!reset) begin
      if (hilo_write) begin
        hi_out = hi_in;
        lo_out = lo_in;
      end else begin
        hi_out = hi[ctx_sel];
        lo_out = lo[ctx_sel];
      end
    end
  end

endmodule
